// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared definitions for the CPU stage sequencer: state encodings (also used by
// the debugger to decode state_dbg) and default parameters.
package cpu_stage_sequencer_pkg;

   localparam int MEM_TIMEOUT_DEFAULT = 15;
   localparam int CNT_W_DEFAULT       = 32;

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_READ   = 3'd2,
      ST_ACCESS = 3'd3,
      ST_WRITE  = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // Stage strobes ordered {fetch, read, access_mem, write}.
   function automatic logic [3:0] stage_strobes(state_t s);
      logic [3:0] strb;
      strb = 4'b0000;
      case (s)
         ST_FETCH:  strb = 4'b1000;
         ST_READ:   strb = 4'b0100;
         ST_ACCESS: strb = 4'b0010;
         ST_WRITE:  strb = 4'b0001;
         default:   strb = 4'b0000;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/cpu_stage_sequencer_if.sv
// Control/debug bundle between the stage sequencer, the debugger and the datapath.
interface cpu_stage_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             mem_rd;
   logic             mem_wr;
   logic             mem_ready;
   logic             halt_req;
   logic             step;
   logic             fetch;
   logic             read;
   logic             access_mem;
   logic             write;
   logic             pc_we;
   logic             halted;
   logic             mem_err;
   logic [CNT_W-1:0] retired;
   logic [2:0]       state_dbg;

   modport master (
      output mem_rd, mem_wr, mem_ready, halt_req, step,
      input  fetch, read, access_mem, write, pc_we, halted, mem_err, retired, state_dbg
   );

   modport slave (
      input  mem_rd, mem_wr, mem_ready, halt_req, step,
      output fetch, read, access_mem, write, pc_we, halted, mem_err, retired, state_dbg
   );
endinterface

// File: rtl/cpu_stage_sequencer_retire.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, synchronous clear wins over increment.
module cpu_retire_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (clr) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multicycle stage sequencer with memory wait states, access timeout,
// debugger halt/single-step and a retired-instruction counter.
//
// state  | meaning
// RST    | held in reset, all strobes low
// FETCH  | instruction fetch strobe
// READ   | register-read strobe
// ACCESS | execute / data-memory access, may wait on mem_ready
// WRITE  | writeback, PC load, instruction retires
// HALT   | stopped for the debugger or after a memory timeout
module cpu_stage_sequencer
   import cpu_stage_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  nreset,
   cpu_stage_sequencer_if.slave  bus
);

   localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [7:0]  wait_inc;
   logic        mem_err_q, mem_err_d;
   logic        step_flag_q, step_flag_d;
   logic [3:0]  strb_q, strb_d;
   logic        pc_we_q, pc_we_d;
   logic        halted_q, halted_d;
   logic        mem_op;
   logic        retire_inc;
   logic [CNT_W-1:0] retired;

   assign mem_op   = bus.mem_rd | bus.mem_wr;
   assign wait_inc = wait_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      mem_err_d   = mem_err_q;
      step_flag_d = step_flag_q;
      case (state_q)
         ST_RST:   state_d = ST_FETCH;
         ST_FETCH: state_d = ST_READ;
         ST_READ: begin
            state_d = ST_ACCESS;
            wait_d  = '0;
         end
         ST_ACCESS: begin
            if (!mem_op || bus.mem_ready) begin
               state_d = ST_WRITE;
            end else if (wait_inc == TIMEOUT_W) begin
               // Timed-out access is abandoned: no writeback, nothing retires.
               state_d     = ST_HALT;
               mem_err_d   = 1'b1;
               step_flag_d = 1'b0;
               wait_d      = wait_inc;
            end else begin
               wait_d = wait_inc;
            end
         end
         ST_WRITE: begin
            state_d     = (bus.halt_req || step_flag_q) ? ST_HALT : ST_FETCH;
            step_flag_d = 1'b0;
         end
         ST_HALT: begin
            if (bus.step) begin
               state_d     = ST_FETCH;
               step_flag_d = 1'b1;
            end else if (!bus.halt_req && !mem_err_q) begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_RST;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      strb_d     = stage_strobes(state_d);
      pc_we_d    = (state_d == ST_WRITE);
      halted_d   = (state_d == ST_HALT);
      retire_inc = (state_d == ST_WRITE);
   end

   always_ff @(posedge clk) begin
      if (nreset) begin
         state_q     <= ST_RST;
         wait_q      <= '0;
         mem_err_q   <= 1'b0;
         step_flag_q <= 1'b0;
         strb_q      <= '0;
         pc_we_q     <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         mem_err_q   <= mem_err_d;
         step_flag_q <= step_flag_d;
         strb_q      <= strb_d;
         pc_we_q     <= pc_we_d;
         halted_q    <= halted_d;
      end
   end

   cpu_retire_counter #(.CNT_W(CNT_W)) u_retire (
      .clk   (clk),
      .clr   (nreset),
      .inc   (retire_inc),
      .count (retired)
   );

   assign bus.fetch      = strb_q[3];
   assign bus.read       = strb_q[2];
   assign bus.access_mem = strb_q[1];
   assign bus.write      = strb_q[0];
   assign bus.pc_we      = pc_we_q;
   assign bus.halted     = halted_q;
   assign bus.mem_err    = mem_err_q;
   assign bus.retired    = retired;
   assign bus.state_dbg  = 3'(state_q);

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed bench for cpu_stage_sequencer: stimulus pushes expected snapshots and
// completion/halt events; a negedge monitor pops and compares them.
module tb_cpu_stage_sequencer;

   localparam int T0 = 3;        // cycle at which reset is first released
   localparam int T1 = T0 + 53;  // cycle at which the mid-test reset is released

   typedef struct {
      int          cyc;
      logic [2:0]  st;
      logic        pc_we;
      logic        halted;
      logic        mem_err;
      logic [31:0] ret;
   } snap_t;

   typedef struct {
      int          kind;   // 0 = pc_we pulse, 1 = halted rising
      int          cyc;
      logic [31:0] ret;
      logic        mem_err;
   } ev_t;

   logic clk = 1'b0;
   logic nreset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic halted_prev = 1'b0;

   snap_t snap_q[$];
   ev_t   ev_q[$];

   cpu_stage_sequencer_if #(.CNT_W(32)) ifc ();

   cpu_stage_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] exp_strb(logic [2:0] st);
      case (st)
         3'd1:    return 4'b1000;
         3'd2:    return 4'b0100;
         3'd3:    return 4'b0010;
         3'd4:    return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic snap(int c, logic [2:0] st, logic pw, logic h, logic e, logic [31:0] r);
      snap_t s;
      s.cyc = c; s.st = st; s.pc_we = pw; s.halted = h; s.mem_err = e; s.ret = r;
      snap_q.push_back(s);
   endtask

   task automatic ev(int k, int c, logic [31:0] r, logic e);
      ev_t x;
      x.kind = k; x.cyc = c; x.ret = r; x.mem_err = e;
      ev_q.push_back(x);
   endtask

   task automatic wait_cyc(int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Monitor
   always @(negedge clk) begin
      snap_t s;
      ev_t   x;
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
         s = snap_q.pop_front();
         chk("state_dbg", 32'(ifc.state_dbg), 32'(s.st));
         chk("strobes", 32'({ifc.fetch, ifc.read, ifc.access_mem, ifc.write}), 32'(exp_strb(s.st)));
         chk("snap_flags", 32'({ifc.pc_we, ifc.halted, ifc.mem_err}), 32'({s.pc_we, s.halted, s.mem_err}));
         chk("snap_retired", ifc.retired, s.ret);
      end
      if (ifc.pc_we === 1'b1) begin
         if (ev_q.size() == 0) chk("unexpected_pc_we", 32'(cyc), 32'hFFFF_FFFF);
         else begin
            x = ev_q.pop_front();
            chk("pc_we_kind", 32'd0, 32'(x.kind));
            chk("pc_we_cycle", 32'(cyc), 32'(x.cyc));
            chk("pc_we_retired", ifc.retired, x.ret);
         end
      end
      if (ifc.halted === 1'b1 && halted_prev !== 1'b1) begin
         if (ev_q.size() == 0) chk("unexpected_halt", 32'(cyc), 32'hFFFF_FFFF);
         else begin
            x = ev_q.pop_front();
            chk("halt_kind", 32'd1, 32'(x.kind));
            chk("halt_cycle", 32'(cyc), 32'(x.cyc));
            chk("halt_retired", ifc.retired, x.ret);
            chk("halt_mem_err", 32'(ifc.mem_err), 32'(x.mem_err));
         end
      end
      halted_prev = ifc.halted;
   end

   initial begin
      ifc.mem_rd = 1'b0; ifc.mem_wr = 1'b0; ifc.mem_ready = 1'b0;
      ifc.halt_req = 1'b0; ifc.step = 1'b0;

      // Reset and free-running ALU instructions
      snap(2, 3'd0, 0, 0, 0, 0);
      snap(T0+1, 3'd1, 0, 0, 0, 0);
      snap(T0+2, 3'd2, 0, 0, 0, 0);
      snap(T0+3, 3'd3, 0, 0, 0, 0);
      snap(T0+4, 3'd4, 1, 0, 0, 1);
      ev(0, T0+4, 1, 0);
      ev(0, T0+8, 2, 0);
      ev(0, T0+12, 3, 0);
      wait_cyc(T0);
      nreset = 1'b0;

      // Load with three wait states
      snap(T0+18, 3'd3, 0, 0, 0, 3);
      snap(T0+19, 3'd4, 1, 0, 0, 4);
      ev(0, T0+19, 4, 0);
      wait_cyc(T0+12);
      ifc.mem_rd = 1'b1;
      wait_cyc(T0+18);
      ifc.mem_ready = 1'b1;
      wait_cyc(T0+19);
      ifc.mem_rd = 1'b0; ifc.mem_ready = 1'b0;

      // Store that never completes: timeout, then one step
      ifc.mem_wr = 1'b1;
      snap(T0+36, 3'd3, 0, 0, 0, 4);
      snap(T0+37, 3'd5, 0, 1, 1, 4);
      snap(T0+40, 3'd5, 0, 1, 1, 4);
      snap(T0+44, 3'd4, 1, 0, 1, 5);
      snap(T0+47, 3'd5, 0, 1, 1, 5);
      ev(1, T0+37, 4, 1);
      ev(0, T0+44, 5, 1);
      ev(1, T0+45, 5, 1);
      wait_cyc(T0+37);
      ifc.mem_wr = 1'b0;
      wait_cyc(T0+40);
      ifc.step = 1'b1;
      wait_cyc(T0+41);
      ifc.step = 1'b0;

      // Reset while a stepped load waits in ACCESS
      snap(T0+52, 3'd3, 0, 0, 1, 5);
      snap(T0+53, 3'd0, 0, 0, 0, 0);
      snap(T1+1, 3'd1, 0, 0, 0, 0);
      wait_cyc(T0+47);
      ifc.step = 1'b1; ifc.mem_rd = 1'b1;
      wait_cyc(T0+48);
      ifc.step = 1'b0;
      wait_cyc(T0+52);
      nreset = 1'b1;
      wait_cyc(T1);
      nreset = 1'b0; ifc.mem_rd = 1'b0;

      // Step pulses while running are ignored
      ev(0, T1+4, 1, 0);
      snap(T1+8, 3'd4, 1, 0, 0, 2);
      ev(0, T1+8, 2, 0);
      foreach (ev_q[i]) begin end
      wait_cyc(T1+2); ifc.step = 1'b1;
      wait_cyc(T1+3); ifc.step = 1'b0;
      wait_cyc(T1+4); ifc.step = 1'b1;
      wait_cyc(T1+5); ifc.step = 1'b1;
      wait_cyc(T1+6); ifc.step = 1'b0;

      // halt_req during READ, two single steps, then resume
      ev(0, T1+12, 3, 0);
      ev(1, T1+13, 3, 0);
      snap(T1+13, 3'd5, 0, 1, 0, 3);
      ev(0, T1+19, 4, 0);
      ev(1, T1+20, 4, 0);
      snap(T1+20, 3'd5, 0, 1, 0, 4);
      ev(0, T1+26, 5, 0);
      ev(1, T1+27, 5, 0);
      snap(T1+29, 3'd5, 0, 1, 0, 5);
      snap(T1+30, 3'd1, 0, 0, 0, 5);
      snap(T1+33, 3'd4, 1, 0, 0, 6);
      ev(0, T1+33, 6, 0);
      wait_cyc(T1+10); ifc.halt_req = 1'b1;
      wait_cyc(T1+15); ifc.step = 1'b1;
      wait_cyc(T1+16); ifc.step = 1'b0;
      wait_cyc(T1+22); ifc.step = 1'b1;
      wait_cyc(T1+23); ifc.step = 1'b0;
      wait_cyc(T1+29); ifc.halt_req = 1'b0;

      wait_cyc(T1+36);
      chk("pending_snapshots", 32'(snap_q.size()), 32'd0);
      chk("pending_events", 32'(ev_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
- Multicycle sequencer for the single-issue CPU. It generates the one-hot stage strobes fetch/read/access_mem/write and the PC write enable.
- Adds memory wait-state handling, a debugger halt/single-step facility and a retired-instruction counter.
- Sits between the serial debugger interface and the datapath (fetch unit, register file, data memory, PC register).

Parameters:
- MEM_TIMEOUT, 15, maximum ACCESS wait cycles before a memory error is flagged (1..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  synchronous reset, active-high.
- mem_rd  in  1  current instruction reads data memory (control MemRead).
- mem_wr  in  1  current instruction writes data memory (control MemWrite).
- mem_ready  in  1  data memory has completed the access this cycle.
- halt_req  in  1  level input from the debugger; requests a halt at the next instruction boundary.
- step  in  1  single-cycle pulse; while halted, executes exactly one instruction.
- fetch  out  1  FETCH stage strobe.
- read  out  1  register-read stage strobe.
- access_mem  out  1  memory/execute stage strobe.
- write  out  1  writeback stage strobe.
- pc_we  out  1  PC load enable; asserted only in WRITE when the instruction completes normally.
- halted  out  1  sequencer is in HALT.
- mem_err  out  1  sticky flag; a memory access timed out.
- retired  out  CNT_W  count of completed instructions.
- state_dbg  out  3  encoded current state, for the debug port.

Behaviour:
- All outputs are registered (Moore). Stage strobes are one-hot or all zero.
- States and encodings: RST=0, FETCH=1, READ=2, ACCESS=3, WRITE=4, HALT=5.
- Reset: while nreset=1, the state is RST and fetch/read/access_mem/write/pc_we/halted/mem_err=0, retired=0, wait count=0. Reset applied mid-instruction aborts that instruction with no pc_we.
- RST -> FETCH on the first cycle with nreset=0.
- FETCH -> READ -> ACCESS unconditionally, one cycle each.
- ACCESS when mem_rd=0 and mem_wr=0: exactly 1 cycle, then WRITE. mem_ready is ignored.
- ACCESS when mem_rd or mem_wr is 1: stay in ACCESS until mem_ready=1, then go to WRITE the next cycle. mem_ready sampled in the first ACCESS cycle gives zero wait states.
- Wait counter: increments on each ACCESS cycle with mem_ready=0 and clears on entry to ACCESS.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, mem_err is set and the state goes to HALT.
  - No WRITE, pc_we or retired increment occurs in this case.
- mem_rd and mem_wr both 1 is treated as a memory access (wait for mem_ready).
- WRITE lasts 1 cycle with pc_we=1 and retired+1. retired wraps modulo 2^CNT_W.
  - Next state after WRITE: HALT if halt_req=1 or the instruction was started by step; otherwise FETCH.
- HALT: all strobes 0, halted=1.
  - step=1 -> FETCH, with a single-step flag set so the instruction returns to HALT after its WRITE.
  - Otherwise, if halt_req=0 and mem_err=0 -> FETCH.
  - While mem_err=1, only step or reset leaves HALT.
- halt_req asserted mid-instruction never truncates that instruction; the halt takes effect after WRITE.
- step outside HALT is ignored.
- mem_err is cleared only by reset.
- Instruction latency: 4 cycles, plus memory wait cycles.

Decomposition:
- Shared package: state encodings (RST..HALT) and the default MEM_TIMEOUT, shared with the debugger so it can decode state_dbg.
- One natural sub-module, cpu_retire_counter: a CNT_W counter with a synchronous clear.
- The FSM and wait counter stay in the top module.

Test Plan:
- Reset release, halt_req=0, no memory ops: strobe sequence FETCH,READ,ACCESS,WRITE repeats with period 4. pc_we high on cycles 4, 8, 12 after release; retired=3 at cycle 12.
- Load with mem_rd=1, mem_ready arriving 3 cycles into ACCESS: ACCESS held 4 cycles; instruction latency 7; one pc_we pulse.
- mem_wr=1, mem_ready never asserted, MEM_TIMEOUT=15: after 15 wait cycles mem_err=1, halted=1, no pc_we, retired unchanged. halt_req=0 does not resume; one step pulse runs exactly one instruction.
- halt_req raised during READ: the instruction completes with one pc_we, then HALT. Two step pulses retire exactly 2 instructions, returning to HALT after each. Dropping halt_req resumes FETCH the next cycle.
- nreset asserted during ACCESS of a waiting load: next cycle all strobes 0, retired=0, mem_err=0, no pc_we. FETCH follows one cycle after nreset drops.
- step pulsed while running (not halted): no effect on the sequence or on retired.
